// File: rtl/wb_spram_pkg.sv
// rtl/wb_spram_pkg.sv - shared state enum, sel-width derivation and sel compare helpers
package wb_spram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } ctrl_state_t;

  // Widest byte-select the helpers accept (128-bit data).
  localparam int SEL_MAX = 16;

  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic sel_all_ones(input logic [SEL_MAX-1:0] sel, input int width);
    logic ones;
    ones = 1'b1;
    for (int i = 0; i < SEL_MAX; i++) begin
      if ((i < width) && !sel[i]) ones = 1'b0;
    end
    return ones;
  endfunction

  function automatic logic sel_is_zero(input logic [SEL_MAX-1:0] sel);
    return (sel == '0);
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// rtl/wb_byte_merge.sv - per-byte-lane select between new and old data words
module wb_byte_merge #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [DATA_WIDTH-1:0] old_data,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_lane
    assign merged[8*i +: 8] = sel[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/wb_spram_ctrl.sv
// rtl/wb_spram_ctrl.sv - Wishbone B4 pipelined slave driving the spram port directly
// WB_SPRAM_RMW_EN enables read-modify-write for partial byte-select writes.
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = sel_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  output logic                  ram_cen,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic stall, accept, sel_ones, sel_zero;
  logic ack_q, err_q, rd_q;
  logic ack_d, err_d, rd_d;

  assign sel_ones = sel_all_ones(SEL_MAX'(wb_sel_i), SEL_WIDTH);
  assign sel_zero = sel_is_zero(SEL_MAX'(wb_sel_i));

`ifdef WB_SPRAM_RMW_EN
  ctrl_state_t           state, state_next;
  logic                  cap_load;
  logic [ADDR_WIDTH-1:0] cap_adr;
  logic [DATA_WIDTH-1:0] cap_dat, merged;
  logic [SEL_WIDTH-1:0]  cap_sel;

  assign stall = (state == RMW_WR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_adr <= '0;
      cap_dat <= '0;
      cap_sel <= '0;
    end else if (cap_load) begin
      cap_adr <= wb_adr_i;
      cap_dat <= wb_dat_i;
      cap_sel <= wb_sel_i;
    end
  end

  wb_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_merge (
    .new_data(cap_dat),
    .old_data(ram_q),
    .sel     (cap_sel),
    .merged  (merged)
  );
`else
  assign stall = 1'b0;
`endif

  // Reset gating keeps the RAM port quiet while a request is held through reset.
  assign accept = reset_n & wb_cyc_i & wb_stb_i & ~stall;

  always_comb begin
    ram_cen     = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rd_d        = 1'b0;
`ifdef WB_SPRAM_RMW_EN
    state_next  = state;
    cap_load    = 1'b0;
    if (state == RMW_WR) begin
      ram_cen     = 1'b1;
      ram_wren    = 1'b1;
      ram_address = cap_adr;
      ram_data    = merged;
      ack_d       = wb_cyc_i;
      state_next  = IDLE;
    end else
`endif
    if (accept) begin
      if (!wb_we_i) begin
        ram_cen     = 1'b1;
        ram_address = wb_adr_i;
        ack_d       = 1'b1;
        rd_d        = 1'b1;
      end else if (sel_ones) begin
        ram_cen     = 1'b1;
        ram_wren    = 1'b1;
        ram_address = wb_adr_i;
        ram_data    = wb_dat_i;
        ack_d       = 1'b1;
      end else if (sel_zero) begin
        ack_d = 1'b1;
      end else begin
`ifdef WB_SPRAM_RMW_EN
        ram_cen     = 1'b1;
        ram_address = wb_adr_i;
        cap_load    = 1'b1;
        state_next  = RMW_WR;
`else
        err_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  // A master that drops cyc abandons any response still in flight.
  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_err_o   = err_q & wb_cyc_i;
  assign wb_dat_o   = (wb_ack_o & rd_q) ? ram_q : '0;
  assign wb_stall_o = stall;

endmodule

// File: doc/wb_spram_ctrl.md
# wb_spram_ctrl

Wishbone B4 pipelined slave that fronts the J1 single-port data RAM (`spram`) and drives its clock-enabled port directly. It turns bus cycles into RAM accesses: single-cycle throughput for reads and full-word writes, and read-modify-write for byte-select writes. It sits between the Wishbone interconnect and the `spram` instance, with no buffering beyond one outstanding access.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: word-address width; matches spram `addr_width` (0x10000 words).
- `DATA_WIDTH`, 16: bus and RAM data width; must be a multiple of 8.
- `SEL_WIDTH`, `DATA_WIDTH/8`: byte-select width; derived, not overridden.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_cyc_i`  in  1  bus cycle active.
- `wb_stb_i`  in  1  request strobe.
- `wb_we_i`  in  1  1 = write.
- `wb_adr_i`  in  ADDR_WIDTH  word address.
- `wb_dat_i`  in  DATA_WIDTH  write data.
- `wb_sel_i`  in  SEL_WIDTH  byte selects; bit i covers bits [8i+7:8i].
- `wb_dat_o`  out  DATA_WIDTH  read data; 0 unless a read ack is asserted.
- `wb_ack_o`  out  1  completion.
- `wb_err_o`  out  1  error completion.
- `wb_stall_o`  out  1  request not accepted this cycle.
- `ram_address`  out  ADDR_WIDTH  to spram `address`.
- `ram_data`  out  DATA_WIDTH  to spram `data`.
- `ram_wren`  out  1  to spram `wren`.
- `ram_cen`  out  1  to spram `cen`.
- `ram_q`  in  DATA_WIDTH  from spram `q`, valid one cycle after a `ram_cen` cycle.

## Operation
- Accept condition: `wb_cyc_i & wb_stb_i & !wb_stall_o`.
- States: IDLE and RMW_WR.
- IDLE, accepted read: `ram_cen`=1, `ram_wren`=0, `ram_address`=`wb_adr_i`. Next cycle `wb_ack_o`=1 and `wb_dat_o`=`ram_q`. `wb_sel_i` is ignored; the full word is returned.
- IDLE, accepted write, sel all ones: `ram_cen`=`ram_wren`=1, `ram_data`=`wb_dat_i`. Ack next cycle.
- IDLE, accepted write, sel all zeros: no RAM access. Ack next cycle.
- IDLE, accepted partial write (sel neither all ones nor zero): RAM read issued. Address, data and sel are captured, then go to RMW_WR.
- RMW_WR: `wb_stall_o`=1. `ram_cen`=`ram_wren`=1 at the captured address. `ram_data` takes the captured `wb_dat_i` bytes where sel=1 and `ram_q` bytes where sel=0. Ack next cycle, then return to IDLE.
- RAM control outputs are combinational from the request and state. `ram_cen`=0 whenever nothing is accepted and the state is not RMW_WR.
- `wb_cyc_i` dropped with an access outstanding: a pending ack/err is suppressed. An RMW already in RMW_WR still completes its RAM write, so memory is never left half-updated.
- Reset (async, mid-operation included): state returns to IDLE and pending ack/err are discarded. An interrupted RMW performs no write.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_stall_o`=0, `wb_dat_o`=0, state IDLE. RAM outputs are 0 while no request is presented.
- Latency: read, full/zero-sel write, and error responses complete at accept+1. Partial write completes at accept+2.
- Throughput: 1 access/cycle back to back. A partial write costs one stall cycle.
- Responses return in request order. At most one response is asserted per cycle.
- Stall is asserted only in RMW_WR; it never depends combinationally on `wb_stb_i`.

## Configuration
- `WB_SPRAM_RMW_EN` defined: partial writes use the read-modify-write path above.
- Macro undefined: RMW_WR state and merge logic are removed and `wb_stall_o` is tied 0. A partial write makes no RAM access and asserts `wb_err_o` (not ack) at accept+1. Full and zero-sel writes are unchanged.

## Structure
- Shared package `wb_spram_pkg` holds:
  - the state enum (IDLE, RMW_WR);
  - the `SEL_WIDTH` derivation constant;
  - the all-ones and zero sel compare helpers.
- One sub-module, `wb_byte_merge`: combinational per-byte mux (new data, old data, sel), used in RMW_WR and reusable by other byte-lane slaves.
- `spram` is instantiated by the parent, not inside this block.

## Test plan
- Reset with stb held high, then release: all outputs 0 during reset. First read of 0x0010 returns the preloaded 0xBEEF with ack at accept+1.
- Back-to-back write 0x1234 to 0x0002 (sel=11), then read 0x0002: acks on consecutive cycles, read data 0x1234, no stall.
- With RMW enabled, 0x0002 holds 0x1234, write 0xAB00 with sel=10: one stall cycle, ack at accept+2, readback 0xAB34. A request presented during the stall is accepted the following cycle.
- With RMW disabled, same partial write: `wb_err_o` at accept+1, no ack, readback still 0x1234.
- Write with sel=00 to 0x0003 holding 0x5555: ack at accept+1, `ram_cen` stays 0, readback 0x5555.
- Drop `wb_cyc_i` in RMW_WR with sel=01 and data 0x00CD over 0x1234: no ack seen, readback 0x12CD. Assert reset in the RMW read cycle instead: readback 0x1234.
